// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and width helper
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} hresp_t;
  function automatic int clog2w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: request/grant bundle between AHB masters and the arbiter
interface ahb_bus_arbiter_if
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int MW = clog2w(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0] HTRANS;
  logic HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0] HMASTER;
  logic HMASTLOCK;
  modport slave (input HBUSREQ, HLOCK, HTRANS, HREADY, output HGRANT, HMASTER, HMASTLOCK);
  modport master (output HBUSREQ, HLOCK, HTRANS, HREADY, input HGRANT, HMASTER, HMASTLOCK);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request after ptr (wrapping, ptr itself last), one-hot result
module rr_priority_pick
  import ahb_pkg::*;
#(
  parameter int N = 3,
  parameter int MW = clog2w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);
  always_comb begin
    gnt = '0;
    valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!valid && req[(int'(ptr) + i) % N]) begin
        gnt[(int'(ptr) + i) % N] = 1'b1;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with burst hold limit and locked-transfer support
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD = 16,
  parameter int MW = clog2w(NUM_MASTERS)
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_bus_arbiter_if.slave bus
);
  localparam int HW = clog2w(MAX_HOLD + 1);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  logic [MW-1:0] owner, pick_idx, next_idx, rr_ptr;
  logic [NUM_MASTERS-1:0] pick_gnt, next_gnt;
  logic [HW-1:0] hold_cnt;
  logic pick_vld, lock_tail, keep, burst, changed;
  rr_priority_pick #(.N(NUM_MASTERS), .MW(MW)) u_pick (
    .req(bus.HBUSREQ),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .valid(pick_vld)
  );
  always_comb begin
    owner = '0;
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      owner = bus.HGRANT[i] ? MW'(i) : owner;
      pick_idx = pick_gnt[i] ? MW'(i) : pick_idx;
    end
  end
  // keep the owner for a post-lock tail, a live lock, or an unexpired burst
  assign burst = bus.HTRANS == SEQ || bus.HTRANS == BUSY;
  assign keep = lock_tail || (bus.HLOCK[owner] && bus.HBUSREQ[owner]) ||
                (bus.HBUSREQ[owner] && burst && hold_cnt < HOLD_MAX);
  assign next_gnt = keep ? bus.HGRANT : pick_vld ? pick_gnt : DEF_GNT;
  assign next_idx = keep ? owner : pick_vld ? pick_idx : DEF_IDX;
  assign changed = next_gnt != bus.HGRANT;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.HGRANT <= DEF_GNT;
      bus.HMASTER <= DEF_IDX;
      bus.HMASTLOCK <= 1'b0;
      hold_cnt <= '0;
      lock_tail <= 1'b0;
      rr_ptr <= DEF_IDX;
    end else if (bus.HREADY) begin
      bus.HGRANT <= next_gnt;
      bus.HMASTER <= owner;
      bus.HMASTLOCK <= bus.HLOCK[owner];
      rr_ptr <= changed ? next_idx : rr_ptr;
      hold_cnt <= changed ? '0 : hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1;
      lock_tail <= !lock_tail && bus.HMASTLOCK && !bus.HLOCK[owner];
    end
  end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;
  localparam int N = 3;
  localparam int MH = 4;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();
  ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .MAX_HOLD(MH)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );
  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int g, m, ml, hold, tail, ptr, ng;
  bit keep, nt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: integer owner index, rules applied directly
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      g = 0; m = 0; ml = 0; hold = 0; tail = 0; ptr = 0;
    end else if (bus.HREADY) begin
      keep = tail != 0 || (bus.HLOCK[g] && bus.HBUSREQ[g]) ||
             (bus.HBUSREQ[g] && (bus.HTRANS == 2'b11 || bus.HTRANS == 2'b01) && hold < MH);
      ng = g;
      if (!keep) begin
        ng = 0;
        for (int k = N; k >= 1; k--) if (bus.HBUSREQ[(ptr + k) % N]) ng = (ptr + k) % N;
      end
      nt = tail == 0 && ml != 0 && !bus.HLOCK[g];
      ml = bus.HLOCK[g];
      m = g;
      hold = (ng != g) ? 0 : (hold < MH ? hold + 1 : MH);
      if (ng != g) ptr = ng;
      g = ng;
      tail = nt;
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      chk("model_grant", bus.HGRANT, 32'(1) << g);
      chk("model_hmaster", bus.HMASTER, m);
      chk("model_mastlock", bus.HMASTLOCK, ml);
      chk("onehot", $onehot(bus.HGRANT), 1);
    end
  end

  initial begin
    logic [2:0] eg [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
    int em [4] = '{0, 1, 2, 0};
    bus.HBUSREQ = '0; bus.HLOCK = '0; bus.HTRANS = 2'b00; bus.HREADY = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (10) begin
      @(negedge HCLK);
      chk("rst_grant", bus.HGRANT, 3'b001);
      chk("rst_hmaster", bus.HMASTER, 0);
      chk("rst_mastlock", bus.HMASTLOCK, 0);
    end
    bus.HBUSREQ = 3'b111; bus.HTRANS = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("rr_grant", bus.HGRANT, eg[i]);
      chk("rr_hmaster", bus.HMASTER, em[i]);
    end
    bus.HREADY = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      chk("stall_grant", bus.HGRANT, 3'b010);
      chk("stall_hmaster", bus.HMASTER, 0);
    end
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    chk("unstall_grant", bus.HGRANT, 3'b100);
    chk("unstall_hmaster", bus.HMASTER, 1);
    bus.HBUSREQ = 3'b010;
    @(negedge HCLK);
    chk("burst_start", bus.HGRANT, 3'b010);
    bus.HBUSREQ = 3'b011; bus.HTRANS = 2'b11;
    repeat (MH) begin
      @(negedge HCLK);
      chk("burst_hold", bus.HGRANT, 3'b010);
    end
    @(negedge HCLK);
    chk("burst_limit", bus.HGRANT, 3'b001);
    bus.HBUSREQ = 3'b111; bus.HLOCK = 3'b100; bus.HTRANS = 2'b10;
    repeat (2) @(negedge HCLK);
    chk("lock_owner", bus.HGRANT, 3'b100);
    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      chk("lock_grant", bus.HGRANT, 3'b100);
      chk("lock_mastlock", bus.HMASTLOCK, 1);
    end
    bus.HLOCK = 3'b000;
    @(negedge HCLK);
    chk("unlock_grant", bus.HGRANT, 3'b001);
    chk("unlock_hmaster", bus.HMASTER, 2);
    @(negedge HCLK);
    chk("tail_grant", bus.HGRANT, 3'b001);
    chk("tail_hmaster", bus.HMASTER, 0);
    @(negedge HCLK);
    chk("post_tail_grant", bus.HGRANT, 3'b010);
    bus.HBUSREQ = 3'b010; bus.HTRANS = 2'b11;
    @(posedge HCLK);
    #2;
    chk("pre_areset_hmaster", bus.HMASTER, 1);
    HRESETn = 1'b0;
    #1;
    chk("areset_grant", bus.HGRANT, 3'b001);
    chk("areset_hmaster", bus.HMASTER, 0);
    chk("areset_mastlock", bus.HMASTLOCK, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3000) begin
      @(negedge HCLK);
      bus.HBUSREQ = 3'($urandom);
      bus.HLOCK = ($urandom_range(0, 3) == 0) ? 3'($urandom) & bus.HBUSREQ : 3'b000;
      bus.HTRANS = 2'($urandom);
      bus.HREADY = $urandom_range(0, 3) != 0;
    end
    @(negedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
